fully_connected_stream: RTL

Sequential fully-connected layer that consumes the flattened conv-core output stream one value at a time, fetches weights from a synchronous ROM, and accumulates all neurons with a single shared multiplier. After the last input it adds biases, saturates, and emits logits serially for the logit RAM writer. It also reports the argmax class. It replaces the combinational FC stage (full weight array in registers) with a parametrised, ROM-backed, handshaked datapath placed between the last conv core and the output RAM.

---
 rtl/fully_connected_stream.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fully_connected_stream.sv
// Sequential fully-connected layer: one shared multiplier walks ROM-resident weights
// input-major, then adds biases, saturates and streams logits out with a running argmax.
module fully_connected_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int BASE_ADDR  = 0,
   parameter int N_INPUTS   = 400,
   parameter int N_NEURONS  = 10
) (
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic                            enable_i,
   input  logic                            data_valid_i,
   input  logic [DATA_WIDTH-1:0]           data_i,
   output logic                            hold_data_o,
   output logic [ADDR_WIDTH-1:0]           weight_rdaddress_o,
   input  logic [DATA_WIDTH-1:0]           weight_i,
   input  logic [N_NEURONS*DATA_WIDTH-1:0] biases_i,
   output logic                            logit_valid_o,
   output logic [DATA_WIDTH-1:0]           logit_o,
   output logic [$clog2(N_NEURONS):0]      logit_index_o,
   output logic [$clog2(N_NEURONS):0]      class_o,
   output logic                            done_o,
   output logic                            overflow_o
);

   localparam int IW  = $clog2(N_NEURONS) + 1;
   localparam int JW  = $clog2(N_INPUTS + 1);
   localparam int AW2 = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_EMIT, S_DONE} state_t;

   state_t                        r_state;
   logic signed [AW2-1:0]         r_acc [N_NEURONS];
   logic signed [DATA_WIDTH-1:0]  r_data;
   logic [IW-1:0]                 r_n;
   logic [JW-1:0]                 r_j;
   logic                          r_primed;
   logic [ADDR_WIDTH-1:0]         r_addr;
   logic                          r_hold;
   logic                          r_valid;
   logic                          r_done;
   logic                          r_ovf;
   logic signed [DATA_WIDTH-1:0]  r_logit;
   logic signed [DATA_WIDTH-1:0]  r_max;
   logic [IW-1:0]                 r_index;
   logic [IW-1:0]                 r_class;

   logic signed [AW2-1:0]         w_prod;
   logic signed [AW2-1:0]         w_term;
   logic signed [AW2-1:0]         w_bias [N_NEURONS];
   logic signed [AW2-1:0]         w_src;
   logic [IW-1:0]                 w_emit_idx;
   logic                          w_fits;
   logic signed [DATA_WIDTH-1:0]  w_sat;
   logic                          w_accept;

   assign w_prod   = AW2'(r_data) * AW2'($signed(weight_i));
   assign w_term   = w_prod >>> FRAC_WIDTH;
   assign w_accept = (r_state == S_IDLE) && data_valid_i && !r_hold;

   // Next logit to register: neuron 0 is formed from acc+bias while the bias is being folded in.
   always_comb begin
      w_emit_idx = (r_state == S_BIAS) ? '0 : r_index + IW'(1);
      w_src      = '0;
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
         w_bias[k] = AW2'($signed(biases_i[k*DATA_WIDTH +: DATA_WIDTH]));
         if (w_emit_idx == IW'(k))
            w_src = (r_state == S_BIAS) ? r_acc[k] + w_bias[k] : r_acc[k];
      end
      w_fits = (&w_src[AW2-1:DATA_WIDTH-1]) | ~(|w_src[AW2-1:DATA_WIDTH-1]);
      if (w_fits)
         w_sat = w_src[DATA_WIDTH-1:0];
      else if (w_src[AW2-1])
         w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state  <= S_IDLE;
         for (int unsigned k = 0; k < N_NEURONS; k++) r_acc[k] <= '0;
         r_data   <= '0;
         r_n      <= '0;
         r_j      <= '0;
         r_primed <= 1'b0;
         r_addr   <= ADDR_WIDTH'(BASE_ADDR);
         r_hold   <= 1'b1;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_logit  <= '0;
         r_max    <= '0;
         r_index  <= '0;
         r_class  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_hold <= !enable_i;
               if (w_accept) begin
                  r_data   <= $signed(data_i);
                  r_hold   <= 1'b1;
                  r_n      <= '0;
                  r_primed <= 1'b0;
                  r_state  <= S_MAC;
               end
            end
            // First MAC cycle only primes the ROM; weight (j,n) lands one cycle after its address.
            S_MAC: begin
               if (!r_primed) begin
                  r_primed <= 1'b1;
                  if (N_NEURONS > 1) r_addr <= r_addr + ADDR_WIDTH'(1);
               end else begin
                  for (int unsigned k = 0; k < N_NEURONS; k++)
                     if (r_n == IW'(k)) r_acc[k] <= r_acc[k] + w_term;
                  if (r_n == IW'(N_NEURONS - 1)) begin
                     r_addr <= r_addr + ADDR_WIDTH'(1);
                     r_j    <= r_j + JW'(1);
                     if (r_j == JW'(N_INPUTS - 1)) begin
                        r_state <= S_BIAS;
                     end else begin
                        r_hold  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_n <= r_n + IW'(1);
                     if (r_n < IW'(N_NEURONS - 2)) r_addr <= r_addr + ADDR_WIDTH'(1);
                  end
               end
            end
            S_BIAS: begin
               for (int unsigned k = 0; k < N_NEURONS; k++) r_acc[k] <= r_acc[k] + w_bias[k];
               r_valid <= 1'b1;
               r_index <= '0;
               r_logit <= w_sat;
               r_max   <= w_sat;
               r_class <= '0;
               if (!w_fits) r_ovf <= 1'b1;
               r_state <= S_EMIT;
            end
            S_EMIT: begin
               if (r_index == IW'(N_NEURONS - 1)) begin
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_index <= w_emit_idx;
                  r_logit <= w_sat;
                  if (w_sat > r_max) begin
                     r_max   <= w_sat;
                     r_class <= w_emit_idx;
                  end
                  if (!w_fits) r_ovf <= 1'b1;
               end
            end
            S_DONE: begin
               if (!enable_i) begin
                  for (int unsigned k = 0; k < N_NEURONS; k++) r_acc[k] <= '0;
                  r_j     <= '0;
                  r_ovf   <= 1'b0;
                  r_done  <= 1'b0;
                  r_addr  <= ADDR_WIDTH'(BASE_ADDR);
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hold_data_o        = r_hold;
   assign weight_rdaddress_o = r_addr;
   assign logit_valid_o      = r_valid;
   assign logit_o            = r_logit;
   assign logit_index_o      = r_index;
   assign class_o            = r_class;
   assign done_o             = r_done;
   assign overflow_o         = r_ovf;

endmodule
